// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage skid buffer: buffer state encoding,
// bit positions inside the packed MEM/WB control field, and an occupancy helper.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    // Bit positions inside the packed control field
    localparam int CTRL_MEM_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_PC_TO_REG  = 4;
    localparam int CTRL_HALT       = 5;
    localparam int CTRL_BITS       = 6;

    function automatic logic [1:0] state_occupancy(input skid_state_e s);
        logic [1:0] occ;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipeline_entry_reg.sv
// Enable-gated storage for one packed pipeline entry; asynchronous active-low clear.
module pipeline_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Two-entry skid buffer between pipeline stages with a registered in_ready,
// flush support and the architectural condition-flag register.
module pipeline_stage_skid
    import pipeline_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CTRL_W  = 6,
    parameter int RADDR_W = 4,
    parameter int FLAG_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_rt,
    input  logic [RADDR_W-1:0] in_dst,
    input  logic [RADDR_W-1:0] in_src2,
    input  logic [FLAG_W-1:0]  in_flags,
    input  logic               in_flags_set,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_alu,
    output logic [DATA_W-1:0]  out_rt,
    output logic [RADDR_W-1:0] out_dst,
    output logic [RADDR_W-1:0] out_src2,
    output logic [FLAG_W-1:0]  out_flags,
    output logic [1:0]         occupancy
);

    localparam int ENTRY_W = CTRL_W + 2 * DATA_W + 2 * RADDR_W;
    localparam int HEAD    = 0;
    localparam int TAIL    = 1;

    skid_state_e        state_reg;
    skid_state_e        state_next;
    logic               in_ready_reg;
    logic [FLAG_W-1:0]  flags_reg;

    logic               accept;
    logic               consume;
    logic               head_from_tail;
    logic [ENTRY_W-1:0] in_entry;
    logic [CTRL_W-1:0]  head_ctrl;

    logic               entry_en [2];
    logic [ENTRY_W-1:0] entry_d  [2];
    logic [ENTRY_W-1:0] entry_q  [2];

    assign in_entry  = {in_ctrl, in_alu, in_rt, in_dst, in_src2};
    assign accept    = in_valid && in_ready_reg;
    assign consume   = out_valid && out_ready;
    assign out_valid = (state_reg != ST_EMPTY);

    always_comb begin
        state_next     = state_reg;
        entry_en[HEAD] = 1'b0;
        entry_en[TAIL] = 1'b0;
        head_from_tail = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        entry_en[HEAD] = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, consume})
                        2'b10: begin
                            entry_en[TAIL] = 1'b1;
                            state_next     = ST_FULL;
                        end
                        2'b01: state_next = ST_EMPTY;
                        // Pass-through: the new entry replaces the departing head
                        2'b11: entry_en[HEAD] = 1'b1;
                        default: state_next = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (consume) begin
                        entry_en[HEAD] = 1'b1;
                        head_from_tail = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    assign entry_d[HEAD] = head_from_tail ? entry_q[TAIL] : in_entry;
    assign entry_d[TAIL] = in_entry;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            pipeline_entry_reg #(
                .W (ENTRY_W)
            ) u_entry (
                .clk (clk),
                .rst (rst),
                .en  (entry_en[gi]),
                .d   (entry_d[gi]),
                .q   (entry_q[gi])
            );
        end
    endgenerate

    // in_ready stays low through reset and rises on the first clock after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b0;
            flags_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_FULL);
            if (accept && in_flags_set) begin
                flags_reg <= in_flags;
            end
        end
    end

    assign {head_ctrl, out_alu, out_rt, out_dst, out_src2} = entry_q[HEAD];
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign in_ready  = in_ready_reg;
    assign out_flags = flags_reg;
    assign occupancy = state_occupancy(state_reg);

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed and random checks for the pipeline_stage_skid buffer.
module tb_pipeline_stage_skid;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_ctrl;
    logic [15:0] in_alu;
    logic [15:0] in_rt;
    logic [3:0]  in_dst;
    logic [3:0]  in_src2;
    logic [2:0]  in_flags;
    logic        in_flags_set;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_ctrl;
    logic [15:0] out_alu;
    logic [15:0] out_rt;
    logic [3:0]  out_dst;
    logic [3:0]  out_src2;
    logic [2:0]  out_flags;
    logic [1:0]  occupancy;

    int total;
    int bad;

    localparam logic [5:0] CTRL_VAL = 6'b100101;

    pipeline_stage_skid dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_alu       (in_alu),
        .in_rt        (in_rt),
        .in_dst       (in_dst),
        .in_src2      (in_src2),
        .in_flags     (in_flags),
        .in_flags_set (in_flags_set),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_alu      (out_alu),
        .out_rt       (out_rt),
        .out_dst      (out_dst),
        .out_src2     (out_src2),
        .out_flags    (out_flags),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_ctrl !== 6'd0) begin bad++; $display("FAIL reset_out_ctrl got=%0h want=0", out_ctrl); end
        total++; if (out_flags !== 3'd0) begin bad++; $display("FAIL reset_out_flags got=%0b want=0", out_flags); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        #3 rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_release_in_ready got=%0b want=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_first_clk_in_ready got=%0b want=1", in_ready); end
        $display("reset: in_ready=%0b occupancy=%0d", in_ready, occupancy);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_alu   = 16'(i);
            in_rt    = 16'(i + 16'h100);
            tick();
            total++; if (out_alu !== 16'(i)) begin bad++; $display("FAIL stream_alu_%0d got=%04h want=%04h", i, out_alu, 16'(i)); end
            total++; if (out_rt !== 16'(i + 16'h100)) begin bad++; $display("FAIL stream_rt_%0d got=%04h want=%04h", i, out_rt, 16'(i + 16'h100)); end
            total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ_%0d got=%0d want=1", i, occupancy); end
            total++; if (out_ctrl !== CTRL_VAL) begin bad++; $display("FAIL stream_ctrl_%0d got=%0h want=%0h", i, out_ctrl, CTRL_VAL); end
            $display("stream: beat=%0d out_alu=%04h occupancy=%0d", i, out_alu, occupancy);
        end
        in_valid = 1'b0;
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL stream_drain_occ got=%0d want=0", occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_alu    = 16'h00AA;
        tick();
        in_alu = 16'h00BB;
        tick();
        in_valid = 1'b0;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_occ got=%0d want=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
        total++; if (out_alu !== 16'h00AA) begin bad++; $display("FAIL stall_head got=%04h want=00aa", out_alu); end
        tick();
        total++; if (out_alu !== 16'h00AA) begin bad++; $display("FAIL stall_hold got=%04h want=00aa", out_alu); end
        out_ready = 1'b1;
        tick();
        total++; if (out_alu !== 16'h00BB) begin bad++; $display("FAIL stall_release got=%04h want=00bb", out_alu); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stall_release_occ got=%0d want=1", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b want=1", in_ready); end
        $display("stall: released head=%04h occupancy=%0d", out_alu, occupancy);
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL stall_drain_occ got=%0d want=0", occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_alu    = 16'h0011;
        tick();
        in_alu = 16'h0022;
        tick();
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_fill_occ got=%0d want=2", occupancy); end
        flush  = 1'b1;
        in_alu = 16'h00CC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b want=0", out_valid); end
        total++; if (out_ctrl !== 6'd0) begin bad++; $display("FAIL flush_out_ctrl got=%0h want=0", out_ctrl); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b want=1", in_ready); end
        tick();
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_lost_occ got=%0d want=0", occupancy); end
        $display("flush: out_valid=%0b occupancy=%0d", out_valid, occupancy);
    endtask

    task automatic test_flags();
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        in_flags     = 3'b101;
        in_flags_set = 1'b1;
        tick();
        total++; if (out_flags !== 3'b101) begin bad++; $display("FAIL flags_load got=%03b want=101", out_flags); end
        in_flags     = 3'b010;
        in_flags_set = 1'b0;
        tick();
        total++; if (out_flags !== 3'b101) begin bad++; $display("FAIL flags_hold got=%03b want=101", out_flags); end
        in_valid     = 1'b0;
        in_flags_set = 1'b1;
        tick();
        total++; if (out_flags !== 3'b101) begin bad++; $display("FAIL flags_noaccept got=%03b want=101", out_flags); end
        in_flags_set = 1'b0;
        $display("flags: out_flags=%03b", out_flags);
    endtask

    task automatic test_reset_full();
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        in_flags     = 3'b110;
        in_flags_set = 1'b1;
        in_alu       = 16'h0033;
        tick();
        in_alu = 16'h0044;
        tick();
        in_valid     = 1'b0;
        in_flags_set = 1'b0;
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL rstfull_fill_occ got=%0d want=2", occupancy); end
        #2 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstfull_out_valid got=%0b want=0", out_valid); end
        total++; if (out_flags !== 3'd0) begin bad++; $display("FAIL rstfull_out_flags got=%03b want=000", out_flags); end
        total++; if (out_ctrl !== 6'd0) begin bad++; $display("FAIL rstfull_out_ctrl got=%0h want=0", out_ctrl); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstfull_in_ready got=%0b want=0", in_ready); end
        #3 rst = 1'b1;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstfull_release_ready got=%0b want=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rstfull_release_occ got=%0d want=0", occupancy); end
        $display("reset_full: in_ready=%0b occupancy=%0d", in_ready, occupancy);
    endtask

    task automatic test_random();
        logic [15:0] sb[$];
        logic [15:0] seq;
        logic        acc;
        logic        con;
        int          delivered;
        seq       = 16'h1000;
        delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_alu    = seq;
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            total++; if (in_ready !== (sb.size() != 2)) begin bad++; $display("FAIL rand_in_ready cyc=%0d got=%0b want=%0b", c, in_ready, (sb.size() != 2)); end
            if (con) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL rand_dup cyc=%0d got=%04h want=none", c, out_alu);
                end else begin
                    if (out_alu !== sb[0]) begin bad++; $display("FAIL rand_order cyc=%0d got=%04h want=%04h", c, out_alu, sb[0]); end
                    void'(sb.pop_front());
                    delivered++;
                end
            end
            if (acc) begin
                sb.push_back(seq);
                seq++;
            end
            tick();
            total++; if (occupancy !== 2'(sb.size())) begin bad++; $display("FAIL rand_occ cyc=%0d got=%0d want=%0d", c, occupancy, sb.size()); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid && sb.size() != 0) begin
                total++; if (out_alu !== sb[0]) begin bad++; $display("FAIL rand_drain got=%04h want=%04h", out_alu, sb[0]); end
                void'(sb.pop_front());
                delivered++;
            end
            tick();
        end
        total++; if (sb.size() != 0 || occupancy !== 2'd0) begin bad++; $display("FAIL rand_loss left=%0d occ=%0d want=0", sb.size(), occupancy); end
        $display("random: accepted=%0d delivered=%0d", seq - 16'h1000, delivered);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        in_ctrl      = CTRL_VAL;
        in_alu       = '0;
        in_rt        = '0;
        in_dst       = 4'd7;
        in_src2      = 4'd3;
        in_flags     = '0;
        in_flags_set = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_flags();
        test_reset_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
